// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side pointer, Gray publish, rptr sync and flags
module fifo_wr_ctrl #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = DEPTH - 2,
  localparam int P_WIDTH    = $clog2(DEPTH)
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic               winc,
  input  logic               wovf_clr,
  input  logic [P_WIDTH:0]   rptr,
  output logic [P_WIDTH-1:0] waddr,
  output logic [P_WIDTH:0]   wptr,
  output logic               wen,
  output logic               wfull,
  output logic               walmost_full,
  output logic [P_WIDTH:0]   wlevel,
  output logic               woverflow
);

  localparam logic [P_WIDTH:0] AF_LVL = (P_WIDTH+1)'(AF_THRESH);

  logic [P_WIDTH:0] wptr_bin;
  logic [P_WIDTH:0] wptr_bin_nxt;
  logic [P_WIDTH:0] rsync [SYNC_STAGES];
  logic [P_WIDTH:0] rptr_s;
  logic [P_WIDTH:0] rbin;

  // A write is only taken when the FIFO is not (pessimistically) full.
  assign wen          = winc & ~wfull;
  assign wptr_bin_nxt = wptr_bin + 1'b1;
  assign waddr        = wptr_bin[P_WIDTH-1:0];

  // Binary write pointer and its registered Gray image advance together,
  // so the published wptr is a clean flop output.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_bin <= '0;
      wptr     <= '0;
    end else if (wen) begin
      wptr_bin <= wptr_bin_nxt;
      wptr     <= wptr_bin_nxt ^ (wptr_bin_nxt >> 1);
    end
  end

  // Plain flop chain bringing the foreign Gray read pointer into wclk.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) rsync[i] <= '0;
    end else begin
      rsync[0] <= rptr;
      for (int i = 1; i < SYNC_STAGES; i++) rsync[i] <= rsync[i-1];
    end
  end

  assign rptr_s = rsync[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= P_WIDTH; i++) rbin[i] = ^(rptr_s >> i);
  end

  // Full when the pointers differ only in the top two Gray bits (one lap apart).
  assign wfull = (wptr == {~rptr_s[P_WIDTH:P_WIDTH-1], rptr_s[P_WIDTH-2:0]});

  assign wlevel       = wptr_bin - rbin;
  assign walmost_full = (wlevel >= AF_LVL);

  // Sticky overflow: a rejected write sets it, and setting beats clearing.
  always_ff @(posedge wclk) begin
    if (wrst)                woverflow <= 1'b0;
    else if (winc && wfull)  woverflow <= 1'b1;
    else if (wovf_clr)       woverflow <= 1'b0;
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - randomized self-checking bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic       wovf_clr = 1'b0;
  logic [3:0] rptr = 4'd0;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wen;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  fifo_wr_ctrl #(.DEPTH(8), .SYNC_STAGES(2), .AF_THRESH(6)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wovf_clr(wovf_clr), .rptr(rptr),
    .waddr(waddr), .wptr(wptr), .wen(wen), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Model state: counts of writes and reads (mod 16), read counts seen
  // one and two edges ago, sticky overflow.
  int m_wcnt = 0;
  int m_rcnt = 0;
  int m_s0   = 0;
  int m_s1   = 0;
  int m_ovf  = 0;
  bit m_init = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int m_level();
    return (m_wcnt - m_s1) & 15;
  endfunction

  // One wclk cycle: drive inputs, check outputs against the model, take the edge.
  task automatic cycle(input logic i_inc, input logic i_clr, input logic i_rst);
    int lvl;
    bit full;
    bit take;
    logic [3:0] prev;
    winc = i_inc; wovf_clr = i_clr; wrst = i_rst; rptr = 4'(gray(m_rcnt));
    #1;
    lvl  = m_level();
    full = (lvl == 8);
    take = i_inc && !full;
    if (m_init) begin
      chk("waddr",  int'(waddr), m_wcnt % 8);
      chk("wptr",   int'(wptr),  gray(m_wcnt));
      chk("wlevel", int'(wlevel), lvl);
      chk("wfull",  int'(wfull), int'(full));
      chk("walmost_full", int'(walmost_full), int'(lvl >= 6));
      chk("woverflow", int'(woverflow), m_ovf);
      chk("wen",    int'(wen), int'(take));
    end
    prev = wptr;
    @(posedge wclk);
    if (i_rst) begin
      m_wcnt = 0; m_s0 = 0; m_s1 = 0; m_ovf = 0; m_init = 1;
    end else begin
      if (i_inc && full) m_ovf = 1;
      else if (i_clr)    m_ovf = 0;
      if (take) m_wcnt = (m_wcnt + 1) & 15;
      m_s1 = m_s0;
      m_s0 = m_rcnt;
    end
    #1;
    if (m_init && !i_rst && take) chk("gray_one_bit", $countones(prev ^ wptr), 1);
    @(negedge wclk);
  endtask

  initial begin
    @(negedge wclk);

    // Reset with a write held high: nothing is taken.
    m_rcnt = 0;
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wptr", int'(wptr), 0);
    chk("rst_wfull", int'(wfull), 0);
    chk("rst_wlevel", int'(wlevel), 0);
    chk("rst_woverflow", int'(woverflow), 0);
    cycle(0, 0, 0);

    // Fill with reads held at zero.
    for (int i = 0; i < 8; i++) begin
      chk("fill_addr", int'(waddr), i);
      cycle(1, 0, 0);
      chk("fill_af", int'(walmost_full), int'(i + 1 >= 6));
    end
    chk("full_wptr", int'(wptr), 4'b1100);
    chk("full_wlevel", int'(wlevel), 8);
    chk("full_wfull", int'(wfull), 1);
    chk("full_waddr", int'(waddr), 0);

    // Overflow set, clear, and set-beats-clear.
    cycle(1, 0, 0);
    chk("ovf_wptr", int'(wptr), 4'b1100);
    chk("ovf_set", int'(woverflow), 1);
    cycle(0, 1, 0);
    chk("ovf_clr", int'(woverflow), 0);
    cycle(1, 1, 0);
    chk("ovf_set_wins", int'(woverflow), 1);
    cycle(0, 1, 0);

    // One read arrives: full persists through the synchronizer.
    m_rcnt = 1;
    cycle(0, 0, 0);
    chk("rel_full_e1", int'(wfull), 1);
    cycle(0, 0, 0);
    chk("rel_full_e2", int'(wfull), 0);
    chk("rel_level", int'(wlevel), 7);
    chk("rel_waddr", int'(waddr), 0);
    cycle(1, 0, 0);
    chk("rel_wptr", int'(wptr), gray(9));

    // Wrap with the reader closely tracking the writer.
    m_rcnt = 0;
    cycle(0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      m_rcnt = m_wcnt;
      cycle(1, 0, 0);
      chk("wrap_nofull", int'(wfull), 0);
      if (i == 14) chk("wrap_g15", int'(wptr), 4'b1000);
      if (i == 15) chk("wrap_g0", int'(wptr), 4'b0000);
    end

    // Random writes and legal reads.
    m_rcnt = 0;
    cycle(0, 0, 1);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 1) == 1 && m_rcnt != m_wcnt) m_rcnt = (m_rcnt + 1) & 15;
      cycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 7) == 0), 1'b0);
      chk("rand_range", int'(wlevel <= 4'd8), 1);
      chk("rand_full_lvl", int'(wfull), int'(wlevel == 4'd8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
